// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-port round-robin arbiter and sequencer in front of a single-port,
//   word-addressed data memory. One access runs at a time. Byte-enabled
//   partial stores become a read-modify-write pair, because the memory only
//   accepts full-word writes.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req0..be0         port 0 (core load/store) request, held until ack0
//   ack0/rdata0/err0  port 0 one-cycle completion, read data, range error
//   req1..err1        port 1 (debug/DMA), same shape as port 0
//   mem_read          memory read enable
//   mem_write         memory write enable (sampled by memory at posedge)
//   mem_address       memory byte address
//   mem_write_data    memory write data
//   mem_read_data     combinational memory read data for mem_address
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic [3:0]  be0,
   output logic        ack0,
   output logic [31:0] rdata0,
   output logic        err0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   input  logic [3:0]  be1,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RMW_WR = 2'd2
   } state_t;

   // Byte-wise merge of new store data over the current memory word.
   function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                               input logic [31:0] new_word,
                                               input logic [31:0] old_word);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         r[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic        rr_q, rr_d;
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] merge_q, merge_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        err0_q, err0_d, err1_q, err1_d;
   logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic        oor;
   logic        elig0, elig1, sel;
   logic        fin, fin_err, fin_rd;
   logic [31:0] fin_rdata;

   assign oor = ({1'b0, addr_q} >= ADDR_LIMIT);

   // Memory bus is decoded from state and latched request only, so a
   // requester changing its inputs can never glitch the memory interface.
   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = 32'd0;
      mem_write_data = 32'd0;
      case (state_q)
         ACCESS: begin
            if (!oor) begin
               if (!we_q) begin
                  mem_read    = 1'b1;
                  mem_address = addr_q;
               end else if (be_q == 4'hF) begin
                  mem_write      = 1'b1;
                  mem_address    = addr_q;
                  mem_write_data = wdata_q;
               end else if (be_q != 4'h0) begin
                  mem_read    = 1'b1;
                  mem_address = addr_q;
               end
            end
         end
         RMW_WR: begin
            mem_write      = 1'b1;
            mem_address    = addr_q;
            mem_write_data = merge_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      merge_d  = merge_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      // A port still holding req during its own ack cycle is not a new request.
      elig0 = req0 & ~ack0_q;
      elig1 = req1 & ~ack1_q;
      sel   = (elig0 & elig1) ? rr_q : elig1;

      fin       = 1'b0;
      fin_err   = 1'b0;
      fin_rd    = 1'b0;
      fin_rdata = 32'd0;

      case (state_q)
         IDLE: begin
            if (elig0 | elig1) begin
               gnt_d   = sel;
               rr_d    = ~sel;
               we_d    = sel ? we1    : we0;
               addr_d  = sel ? addr1  : addr0;
               wdata_d = sel ? wdata1 : wdata0;
               be_d    = sel ? be1    : be0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (oor) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               fin_rd  = ~we_q;
            end else if (!we_q) begin
               fin       = 1'b1;
               fin_rd    = 1'b1;
               fin_rdata = mem_read_data;
            end else if ((be_q == 4'hF) || (be_q == 4'h0)) begin
               fin = 1'b1;
            end else begin
               merge_d = merge_bytes(be_q, wdata_q, mem_read_data);
               state_d = RMW_WR;
            end
            if (fin) begin
               state_d = IDLE;
            end
         end
         RMW_WR: begin
            fin     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (fin) begin
         if (!gnt_q) begin
            ack0_d = 1'b1;
            err0_d = fin_err;
            if (fin_rd) rdata0_d = fin_rdata;
         end else begin
            ack1_d = 1'b1;
            err1_d = fin_err;
            if (fin_rd) rdata1_d = fin_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         be_q     <= 4'd0;
         merge_q  <= 32'd0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         merge_q  <= merge_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign err0   = err0_q;
   assign err1   = err1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter: behavioural memory, transaction-level reference
//   model of arbitration, latency and memory effects, a per-cycle compare
//   process, and directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int MEMW = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [3:0]  be0, be1;
   logic        ack0, err0, ack1, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_WORDS(MEMW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
      .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
      .ack1(ack1), .rdata1(rdata1), .err1(err1),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mrg(input logic [3:0] be, input logic [31:0] nw,
                                       input logic [31:0] old);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? nw[8*k +: 8] : old[8*k +: 8];
      return r;
   endfunction

   // Memory device with a preload port for the bench
   logic [31:0] mem [0:MEMW-1];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   assign mem_read_data = mem[mem_address[11:2]];
   always @(posedge clk) begin
      if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
      else if (pl_en) mem[pl_idx] <= pl_val;
   end

   // Reference model: one transaction at a time; a grant at edge n acks after
   // edge n+1 (n+2 for partial stores); next grant no earlier than the edge
   // after the ack edge; a port is ineligible during its own ack cycle.
   logic [31:0] ref_mem [0:MEMW-1];
   int          cyc = 0;
   int          free_at;
   bit          rr;
   bit          pend [2];
   int          done_at [2];
   bit          t_we [2], t_oor [2], t_part [2];
   logic [31:0] t_addr [2], t_wdata [2];
   logic [3:0]  t_be [2];
   bit          mack [2], merr [2];
   logic [31:0] mrdata [2];
   int          mop;
   logic [31:0] maddr, mwdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_at = 0; rr = 0; mop = 0; maddr = '0; mwdata = '0;
         for (int i = 0; i < 2; i++) begin
            pend[i] = 0; mack[i] = 0; merr[i] = 0; mrdata[i] = '0;
         end
      end else begin
         bit p0, p1, e0, e1, s;
         int L;
         cyc = cyc + 1;
         if (pl_en) ref_mem[pl_idx] = pl_val;
         p0 = mack[0]; p1 = mack[1];
         mop = 0;
         for (int i = 0; i < 2; i++) begin
            mack[i] = 0; merr[i] = 0;
            if (pend[i] && done_at[i] == cyc) begin
               mack[i] = 1; pend[i] = 0;
               if (t_oor[i]) begin
                  merr[i] = 1;
                  if (!t_we[i]) mrdata[i] = '0;
               end else if (!t_we[i]) begin
                  mrdata[i] = ref_mem[t_addr[i][11:2]];
               end else begin
                  ref_mem[t_addr[i][11:2]] = mrg(t_be[i], t_wdata[i], ref_mem[t_addr[i][11:2]]);
               end
            end
            if (pend[i] && t_part[i] && done_at[i] == cyc + 1) begin
               mop = 2; maddr = t_addr[i];
               mwdata = mrg(t_be[i], t_wdata[i], ref_mem[t_addr[i][11:2]]);
            end
         end
         if (cyc >= free_at) begin
            e0 = req0 && !p0;
            e1 = req1 && !p1;
            if (e0 || e1) begin
               s = (e0 && e1) ? rr : e1;
               rr = !s;
               t_we[s]    = s ? we1 : we0;
               t_addr[s]  = s ? addr1 : addr0;
               t_wdata[s] = s ? wdata1 : wdata0;
               t_be[s]    = s ? be1 : be0;
               t_oor[s]   = (longint'(t_addr[s]) >= longint'(MEMW) * 4);
               t_part[s]  = t_we[s] && !t_oor[s] && t_be[s] != 4'h0 && t_be[s] != 4'hF;
               L = t_part[s] ? 2 : 1;
               done_at[s] = cyc + L;
               free_at = cyc + L + 1;
               pend[s] = 1;
               maddr = t_addr[s];
               if (t_oor[s]) mop = 0;
               else if (!t_we[s]) mop = 1;
               else if (t_be[s] == 4'hF) begin mop = 2; mwdata = t_wdata[s]; end
               else if (t_be[s] == 4'h0) mop = 0;
               else mop = 1;
            end
         end
      end
   end

   // Per-cycle compare, sampled on the falling edge
   int rd_cyc = 0, wr_cyc = 0;
   always @(negedge clk) begin
      if (mem_read) rd_cyc++;
      if (mem_write) wr_cyc++;
      chk("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
      if (!rst_n) begin
         chk("rst_ctl", 32'({ack0, ack1, err0, err1, mem_read, mem_write}), 32'd0);
         chk("rst_rdata0", rdata0, 32'd0);
         chk("rst_rdata1", rdata1, 32'd0);
         chk("rst_mem_address", mem_address, 32'd0);
         chk("rst_mem_wdata", mem_write_data, 32'd0);
      end else begin
         chk("ack0", 32'(ack0), 32'(mack[0]));
         chk("ack1", 32'(ack1), 32'(mack[1]));
         chk("err0", 32'(err0), 32'(merr[0]));
         chk("err1", 32'(err1), 32'(merr[1]));
         chk("rdata0", rdata0, mrdata[0]);
         chk("rdata1", rdata1, mrdata[1]);
         chk("mem_read", 32'(mem_read), 32'(mop == 1));
         chk("mem_write", 32'(mem_write), 32'(mop == 2));
         if (mop != 0) chk("mem_address", mem_address, maddr);
         if (mop == 2) chk("mem_write_data", mem_write_data, mwdata);
         if (!pend[0] && !pend[1]) begin
            chk("idle_mem_address", mem_address, 32'd0);
            chk("idle_mem_wdata", mem_write_data, 32'd0);
         end
      end
   end

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 10'(idx); pl_val = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic do_req(input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic err);
      int t0;
      @(negedge clk);
      if (!p) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; be0 = be; end
      else    begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; be1 = be; end
      t0 = cyc; lat = -1; rd = 'x; err = 1'bx;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if ((p ? ack1 : ack0) === 1'b1) begin
            lat = cyc - t0;
            rd  = p ? rdata1 : rdata0;
            err = p ? err1 : err0;
            break;
         end
      end
      if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
      if (!p) req0 = 0; else req1 = 0;
   endtask

   int ack_order [$];
   task automatic tie_run(input int n);
      @(negedge clk);
      req0 = 1; we0 = 0; addr0 = 32'h14; be0 = 4'h0;
      req1 = 1; we1 = 0; addr1 = 32'h0C; be1 = 4'h0;
      ack_order.delete();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ack0) ack_order.push_back(0);
         if (ack1) ack_order.push_back(1);
         if (ack_order.size() >= n) break;
      end
      req0 = 0; req1 = 0;
      chk("tie_ack_count", 32'(ack_order.size()), 32'(n));
   endtask

   initial begin
      int lat, r0, w0, diffs;
      logic [31:0] rd;
      logic err;
      rst_n = 0;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1;

      preload(5, 32'hDEADBEEF);
      preload(3, 32'h11223344);
      preload(7, 32'h55667788);
      preload(0, 32'hCAFEF00D);
      preload(9, 32'hA5A5A5A5);

      // Tie after reset: port 0 first, then strict alternation
      tie_run(4);
      if (ack_order.size() == 4) begin
         chk("tie_order0", 32'(ack_order[0]), 32'd0);
         chk("tie_order1", 32'(ack_order[1]), 32'd1);
         chk("tie_order2", 32'(ack_order[2]), 32'd0);
         chk("tie_order3", 32'(ack_order[3]), 32'd1);
      end
      repeat (3) @(negedge clk);

      // Single read
      r0 = rd_cyc; w0 = wr_cyc;
      do_req(0, 0, 32'h14, 32'h0, 4'h0, lat, rd, err);
      chk("read_latency", 32'(lat), 32'd2);
      chk("read_rdata", rd, 32'hDEADBEEF);
      chk("read_err", 32'(err), 32'd0);
      chk("read_rd_cycles", 32'(rd_cyc - r0), 32'd1);
      chk("read_wr_cycles", 32'(wr_cyc - w0), 32'd0);

      // Partial write -> read-modify-write
      r0 = rd_cyc; w0 = wr_cyc;
      do_req(1, 1, 32'h0C, 32'hAABBCCDD, 4'b0101, lat, rd, err);
      chk("rmw_latency", 32'(lat), 32'd3);
      chk("rmw_err", 32'(err), 32'd0);
      chk("rmw_word", mem[3], 32'h11BB33DD);
      chk("rmw_rd_cycles", 32'(rd_cyc - r0), 32'd1);
      chk("rmw_wr_cycles", 32'(wr_cyc - w0), 32'd1);

      // Out of range read
      r0 = rd_cyc; w0 = wr_cyc;
      do_req(0, 0, 32'h1000, 32'h0, 4'h0, lat, rd, err);
      chk("oor_latency", 32'(lat), 32'd2);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_rdata", rd, 32'd0);
      chk("oor_mem_ops", 32'((rd_cyc - r0) + (wr_cyc - w0)), 32'd0);

      // Empty byte mask
      r0 = rd_cyc; w0 = wr_cyc;
      do_req(1, 1, 32'h1C, 32'hFFFFFFFF, 4'b0000, lat, rd, err);
      chk("be0_latency", 32'(lat), 32'd2);
      chk("be0_word", mem[7], 32'h55667788);
      chk("be0_mem_ops", 32'((rd_cyc - r0) + (wr_cyc - w0)), 32'd0);

      // Full write then read back
      r0 = rd_cyc; w0 = wr_cyc;
      do_req(0, 1, 32'h0, 32'h0, 4'b1111, lat, rd, err);
      chk("full_latency", 32'(lat), 32'd2);
      chk("full_wr_cycles", 32'(wr_cyc - w0), 32'd1);
      chk("full_rd_cycles", 32'(rd_cyc - r0), 32'd0);
      chk("full_word", mem[0], 32'd0);
      do_req(1, 0, 32'h0, 32'h0, 4'h0, lat, rd, err);
      chk("full_readback", rd, 32'd0);

      // Reset while in the write half of a read-modify-write
      @(negedge clk);
      req0 = 1; we0 = 1; addr0 = 32'h24; wdata0 = 32'h0; be0 = 4'b0011;
      @(negedge clk);
      @(negedge clk);
      chk("rmw_wr_active", 32'(mem_write), 32'd1);
      #2 rst_n = 0;
      #1;
      chk("rst_mem_write_now", 32'(mem_write), 32'd0);
      chk("rst_ack0_now", 32'(ack0), 32'd0);
      chk("rst_mem_address_now", mem_address, 32'd0);
      req0 = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_word_untouched", mem[9], 32'hA5A5A5A5);
      #2 rst_n = 1;

      // Round-robin pointer restarts at port 0
      tie_run(2);
      if (ack_order.size() == 2) begin
         chk("post_rst_order0", 32'(ack_order[0]), 32'd0);
         chk("post_rst_order1", 32'(ack_order[1]), 32'd1);
      end
      repeat (2) @(negedge clk);
      do_req(1, 0, 32'h24, 32'h0, 4'h0, lat, rd, err);
      chk("post_rst_read", rd, 32'hA5A5A5A5);

      repeat (3) @(negedge clk);
      diffs = 0;
      for (int i = 0; i < MEMW; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image_diffs", 32'(diffs), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
